// File: rtl/dac_driver.sv
// Multi-channel parallel-bus DAC writer: shadow registers, dirty-channel
// flush on commit, simultaneous LDAC update and power-up DAC reset.
module dac_driver #(
    parameter int NCH          = 6,
    parameter int SETUP_CYCLES = 1,
    parameter int WR_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int LDAC_CYCLES  = 2,
    parameter int RST_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        commit,
    output logic        busy_o,
    output logic        done,
    output logic [15:0] dacdb,
    output logic [2:0]  dacaddr,
    output logic        daccs,
    output logic        dacwr,
    output logic        dacldac,
    output logic        dacrst
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETUP, S_WR, S_HOLD, S_GAP, S_LDAC, S_DONE
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] WR_LAST    = 8'(WR_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] LDAC_LAST  = 8'(LDAC_CYCLES - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [2:0]     ch_q, ch_d;
    logic [NCH-1:0] dirty_q, dirty_d;
    logic [15:0]    shadow_q [NCH];
    logic [15:0]    shadow_d [NCH];
    logic           pending_q, pending_d;
    logic [15:0]    dacdb_q, dacdb_d;
    logic [2:0]     dacaddr_q, dacaddr_d;
    logic           daccs_q, daccs_d;
    logic           dacwr_q, dacwr_d;
    logic           dacldac_q, dacldac_d;
    logic           dacrst_q, dacrst_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           wr_ok;
    logic           first_vld, next_vld;
    logic [2:0]     first_idx, next_idx;
    logic           load;
    logic [2:0]     load_idx;

    assign wr_ok = wr_en && (int'(wr_addr) < NCH);

    // Lowest dirty channel overall, and lowest dirty channel above ch_q.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                first_vld = 1'b1;
                first_idx = 3'(i);
            end
            if (dirty_q[i] && i > int'(ch_q)) begin
                next_vld = 1'b1;
                next_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        dirty_d   = dirty_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        dacdb_d   = dacdb_q;
        dacaddr_d = dacaddr_q;
        load      = 1'b0;
        load_idx  = '0;

        if (commit && state_q != S_IDLE) pending_d = 1'b1;

        unique case (state_q)
            S_INIT:  if (cnt_q == RST_LAST) state_d = S_IDLE;
            S_IDLE: begin
                if (commit || pending_q) begin
                    pending_d = 1'b0;
                    if (first_vld) begin
                        load     = 1'b1;
                        load_idx = first_idx;
                    end else begin
                        state_d = S_LDAC;
                    end
                end
            end
            S_SETUP: if (cnt_q == SETUP_LAST) state_d = S_WR;
            S_WR:    if (cnt_q == WR_LAST) state_d = S_HOLD;
            S_HOLD:  if (cnt_q == HOLD_LAST) state_d = S_GAP;
            S_GAP: begin
                if (next_vld) begin
                    load     = 1'b1;
                    load_idx = next_idx;
                end else begin
                    state_d = S_LDAC;
                end
            end
            S_LDAC:  if (cnt_q == LDAC_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        if (load) begin
            state_d           = S_SETUP;
            ch_d              = load_idx;
            dacdb_d           = shadow_q[load_idx];
            dacaddr_d         = load_idx;
            dirty_d[load_idx] = 1'b0;
        end

        // A same-edge write re-marks the channel so it goes out next commit.
        if (wr_ok) begin
            shadow_d[wr_addr] = wr_data;
            dirty_d[wr_addr]  = 1'b1;
        end

        cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;

        daccs_d   = !(state_d inside {S_SETUP, S_WR, S_HOLD});
        dacwr_d   = (state_d != S_WR);
        dacldac_d = (state_d != S_LDAC);
        dacrst_d  = (state_d == S_INIT);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d == S_IDLE || state_d == S_DONE) ? pending_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            ch_q      <= '0;
            dirty_q   <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
            dacdb_q   <= '0;
            dacaddr_q <= '0;
            daccs_q   <= 1'b1;
            dacwr_q   <= 1'b1;
            dacldac_q <= 1'b1;
            dacrst_q  <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            dacdb_q   <= dacdb_d;
            dacaddr_q <= dacaddr_d;
            daccs_q   <= daccs_d;
            dacwr_q   <= dacwr_d;
            dacldac_q <= dacldac_d;
            dacrst_q  <= dacrst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dacdb   = dacdb_q;
    assign dacaddr = dacaddr_q;
    assign daccs   = daccs_q;
    assign dacwr   = dacwr_q;
    assign dacldac = dacldac_q;
    assign dacrst  = dacrst_q;
    assign busy_o  = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_dac_driver.sv
// Bench for dac_driver: table of write/commit vectors against a shadow
// model and transfer scoreboard, plus hand-built multi-cycle sequences.
module tb_dac_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        busy_o, done, daccs, dacwr, dacldac, dacrst;
    logic [15:0] dacdb;
    logic [2:0]  dacaddr;

    dac_driver dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .busy_o(busy_o), .done(done),
        .dacdb(dacdb), .dacaddr(dacaddr), .daccs(daccs), .dacwr(dacwr),
        .dacldac(dacldac), .dacrst(dacrst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nw;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic [2:0]  a1;
        logic [15:0] d1;
        int          lat;
    } vec_t;

    vec_t        vecs [7];
    int          checks = 0;
    int          errors = 0;
    int          ldac_cnt = 0;
    logic        wr_prev = 1'b1;
    logic [19:0] exp_q [$];
    logic [19:0] obs_q [$];
    logic [15:0] m_sh [6];
    logic [5:0]  m_dirty = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!dacwr && wr_prev) obs_q.push_back({daccs, dacaddr, dacdb});
        wr_prev = dacwr;
        if (!dacldac) ldac_cnt++;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [15:0] d);
        if (a < 3'd6) begin
            m_sh[a]    = d;
            m_dirty[a] = 1'b1;
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 6; i++)
            if (m_dirty[i]) exp_q.push_back({1'b0, 3'(i), m_sh[i]});
        m_dirty = '0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        model_write(a, d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_sb(input string name);
        logic [19:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_missing: got none expected %0h", name, e);
            end else begin
                chk(name, obs_q.pop_front(), e);
            end
        end
        chk({name, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic run_commit(input int exp_lat, input string name);
        int lat;
        int l0;
        model_commit();
        l0 = ldac_cnt;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_done(1, lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_ldac"}, ldac_cnt - l0, 2);
        check_sb(name);
        tick();
        chk({name, "_post"}, {done, busy_o}, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [8:0] cs_m, wr_m, ld_m, dn_m, bz_m;
        int n, lat, c, ndone, d1, d2, l0;
        logic cs_bad, bz_bad, b1;

        vecs[0] = '{1, 3'd2, 16'h1234, 3'd0, 16'h0000, 8};
        vecs[1] = '{2, 3'd5, 16'hAAAA, 3'd0, 16'h5555, 13};
        vecs[2] = '{1, 3'd7, 16'hDEAD, 3'd0, 16'h0000, 3};
        vecs[3] = '{0, 3'd0, 16'h0000, 3'd0, 16'h0000, 3};
        vecs[4] = '{2, 3'd3, 16'hBEEF, 3'd3, 16'hCAFE, 8};
        vecs[5] = '{2, 3'd1, 16'h0001, 3'd4, 16'h0004, 13};
        vecs[6] = '{2, 3'd6, 16'hFFFF, 3'd5, 16'h7777, 8};
        for (int i = 0; i < 6; i++) m_sh[i] = '0;

        // Reset state and power-up DAC reset pulse
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_state",
                {dacrst, daccs, dacwr, dacldac, busy_o, done, dacaddr, dacdb},
                {6'b111110, 3'd0, 16'h0000});
        end
        rst = 1'b0;
        n = 0;
        cs_bad = 1'b0;
        bz_bad = 1'b0;
        while (dacrst && n < 20) begin
            if (!daccs) cs_bad = 1'b1;
            if (!busy_o) bz_bad = 1'b1;
            n++;
            tick();
        end
        chk("init_len", n, 4);
        chk("init_busy_fall", busy_o, 1'b0);
        chk("init_cs_idle", cs_bad, 1'b0);
        chk("init_busy_held", bz_bad, 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].nw > 0) do_write(vecs[i].a0, vecs[i].d0);
            if (vecs[i].nw > 1) do_write(vecs[i].a1, vecs[i].d1);
            run_commit(vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Cycle-exact waveform of a single-channel flush
        do_write(3'd2, 16'h4321);
        model_commit();
        cs_m = '0; wr_m = '0; ld_m = '0; dn_m = '0; bz_m = '0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cs_m[k] = !daccs;
            wr_m[k] = !dacwr;
            ld_m[k] = !dacldac;
            dn_m[k] = done;
            bz_m[k] = busy_o;
            if (k < 8) tick();
        end
        chk("wave_cs", cs_m, 9'b000011110);
        chk("wave_wr", wr_m, 9'b000001100);
        chk("wave_ldac", ld_m, 9'b011000000);
        chk("wave_done", dn_m, 9'b100000000);
        chk("wave_busy", bz_m, 9'b011111110);
        check_sb("wave");
        tick();

        // Write to the channel during its WR phase
        do_write(3'd1, 16'h1111);
        model_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("midwr_phase", dacwr, 1'b0);
        model_write(3'd1, 16'h0F0F);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0F0F;
        tick();
        wr_en = 1'b0;
        wait_done(3, lat);
        chk("midwr_lat", lat, 8);
        check_sb("midwr");
        tick();
        run_commit(8, "midwr_resend");

        // Write on the same edge the channel enters SETUP
        do_write(3'd4, 16'h0001);
        model_commit();
        model_write(3'd4, 16'h0002);
        commit = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0002;
        tick();
        commit = 1'b0;
        wr_en = 1'b0;
        wait_done(1, lat);
        chk("same_edge_lat", lat, 8);
        check_sb("same_edge");
        tick();
        run_commit(8, "same_edge_resend");

        // Two commits and an out-of-range write during a flush
        do_write(3'd3, 16'h3333);
        model_commit();
        l0 = ldac_cnt;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        commit = 1'b1;
        model_write(3'd7, 16'hFFFF);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        tick();
        commit = 1'b0;
        wr_en = 1'b0;
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        c = 5; ndone = 0; d1 = 0; d2 = 0; b1 = 1'b0;
        while (c < 30) begin
            tick();
            c++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = c;
                    b1 = busy_o;
                end else begin
                    d2 = c;
                end
            end
        end
        chk("pend_ndone", ndone, 2);
        chk("pend_done1", d1, 8);
        chk("pend_done2", d2, 12);
        chk("pend_busy", b1, 1'b1);
        chk("pend_ldac", ldac_cnt - l0, 4);
        check_sb("pend");

        // Reset during WR phase
        do_write(3'd2, 16'h2222);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("abort_in_wr", dacwr, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort_bus",
            {daccs, dacwr, dacldac, dacrst, done}, 5'b11110);
        rst = 1'b0;
        m_dirty = '0;
        for (int i = 0; i < 6; i++) m_sh[i] = '0;
        obs_q.delete();
        n = 0;
        ndone = 0;
        while (busy_o && n < 50) begin
            tick();
            n++;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_idle", busy_o, 1'b0);
        run_commit(3, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
